aes128_decrypt_iter: RTL and testbench

Iterative AES-128 decryption core and the inverse of the combinational encryption datapath. It is loaded once with a 128-bit cipher key and expands the key schedule internally, one round key per cycle. It then decrypts one 128-bit block per request, one inverse round per clock, behind valid/ready handshakes on both input and output. It sits at the receive end of the AES link and consumes blocks produced by the encryption top.

---
 rtl/aes128_decrypt_iter.sv | 201 ++++++++++++++++++++
 tb/tb_aes128_decrypt_iter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_decrypt_iter.sv
// Iterative AES-128 inverse cipher: the key schedule is expanded on chip one round key
// per clock after key_load, then each block is decrypted one inverse round per clock.
module aes128_decrypt_iter (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         key_load,
   input  logic [127:0] key,
   output logic         key_ready,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] ciphertext,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] plaintext,
   output logic         busy
);

   typedef enum logic [2:0] {IDLE, EXPAND, READY, ROUND, DONE} state_t;

   function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Field inverse computed as a^254, which conveniently maps 0 to 0.
   function automatic logic [7:0] gfInv(input logic [7:0] a);
      logic [7:0] r;
      logic [7:0] e;
      r = 8'h01;
      e = 8'hfe;
      for (int i = 7; i >= 0; i--) begin
         r = gfMul(r, r);
         if (e[i]) r = gfMul(r, a);
      end
      return r;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] v;
      v = gfInv(a);
      return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] invSbox(input logic [7:0] s);
      logic [7:0] b;
      b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
      return gfInv(b);
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] n);
      case (n)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [31:0] invMixCol(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = col;
      return {gfMul(a0, 8'h0e) ^ gfMul(a1, 8'h0b) ^ gfMul(a2, 8'h0d) ^ gfMul(a3, 8'h09),
              gfMul(a0, 8'h09) ^ gfMul(a1, 8'h0e) ^ gfMul(a2, 8'h0b) ^ gfMul(a3, 8'h0d),
              gfMul(a0, 8'h0d) ^ gfMul(a1, 8'h09) ^ gfMul(a2, 8'h0e) ^ gfMul(a3, 8'h0b),
              gfMul(a0, 8'h0b) ^ gfMul(a1, 8'h0d) ^ gfMul(a2, 8'h09) ^ gfMul(a3, 8'h0e)};
   endfunction

   state_t       r_fsm;
   logic [127:0] r_rk [0:10];
   logic [3:0]   r_kcnt;
   logic [3:0]   r_rcnt;
   logic [127:0] r_data;
   logic         r_keyReady;
   logic         r_outValid;
   logic         r_busy;

   logic [127:0] w_prevKey;
   logic [127:0] w_nextKey;
   logic [31:0]  w_temp;
   logic [127:0] w_roundKey;
   logic [127:0] w_invShift;
   logic [127:0] w_invSub;
   logic [127:0] w_addKey;
   logic [127:0] w_invMix;
   logic [127:0] w_roundOut;

   // Next round key from the previous one: RotWord/SubWord/Rcon on w3, then the xor chain.
   always_comb begin
      w_prevKey = r_rk[(r_kcnt == 4'd0) ? 4'd0 : r_kcnt - 4'd1];
      w_temp    = {sbox(w_prevKey[23:16]), sbox(w_prevKey[15:8]),
                   sbox(w_prevKey[7:0]),   sbox(w_prevKey[31:24])} ^ {rcon(r_kcnt), 24'h000000};
      w_nextKey[127:96] = w_prevKey[127:96] ^ w_temp;
      w_nextKey[95:64]  = w_prevKey[95:64] ^ w_prevKey[127:96] ^ w_temp;
      w_nextKey[63:32]  = w_prevKey[63:32] ^ w_prevKey[95:64] ^ w_prevKey[127:96] ^ w_temp;
      w_nextKey[31:0]   = w_prevKey[31:0] ^ w_prevKey[63:32] ^ w_prevKey[95:64] ^
                          w_prevKey[127:96] ^ w_temp;
   end

   // One inverse round; the last round (rcnt 0) skips InvMixColumns.
   always_comb begin
      w_roundKey = r_rk[r_rcnt];
      w_invShift = '0;
      w_invSub   = '0;
      w_invMix   = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            w_invShift[127 - 8*(r + 4*c) -: 8] = r_data[127 - 8*(r + 4*((c + 4 - r) % 4)) -: 8];
      for (int n = 0; n < 16; n++)
         w_invSub[127 - 8*n -: 8] = invSbox(w_invShift[127 - 8*n -: 8]);
      w_addKey = w_invSub ^ w_roundKey;
      for (int c = 0; c < 4; c++)
         w_invMix[127 - 32*c -: 32] = invMixCol(w_addKey[127 - 32*c -: 32]);
      w_roundOut = (r_rcnt == 4'd0) ? w_addKey : w_invMix;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fsm      <= IDLE;
         r_kcnt     <= 4'd0;
         r_rcnt     <= 4'd0;
         r_data     <= '0;
         r_keyReady <= 1'b0;
         r_outValid <= 1'b0;
         r_busy     <= 1'b0;
         for (int i = 0; i < 11; i++) r_rk[i] <= '0;
      end else begin
         case (r_fsm)
            IDLE: begin
               if (key_load) begin
                  r_rk[0] <= key;
                  r_kcnt  <= 4'd1;
                  r_busy  <= 1'b1;
                  r_fsm   <= EXPAND;
               end
            end
            EXPAND: begin
               r_rk[r_kcnt] <= w_nextKey;
               if (r_kcnt == 4'd10) begin
                  r_keyReady <= 1'b1;
                  r_busy     <= 1'b0;
                  r_fsm      <= READY;
               end else begin
                  r_kcnt <= r_kcnt + 4'd1;
               end
            end
            READY: begin
               if (key_load) begin
                  r_rk[0]    <= key;
                  r_kcnt     <= 4'd1;
                  r_keyReady <= 1'b0;
                  r_busy     <= 1'b1;
                  r_fsm      <= EXPAND;
               end else if (in_valid) begin
                  r_data <= ciphertext ^ r_rk[10];
                  r_rcnt <= 4'd9;
                  r_busy <= 1'b1;
                  r_fsm  <= ROUND;
               end
            end
            ROUND: begin
               r_data <= w_roundOut;
               if (r_rcnt == 4'd0) begin
                  r_outValid <= 1'b1;
                  r_busy     <= 1'b0;
                  r_fsm      <= DONE;
               end else begin
                  r_rcnt <= r_rcnt - 4'd1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_outValid <= 1'b0;
                  r_fsm      <= READY;
               end
            end
            default: r_fsm <= IDLE;
         endcase
      end
   end

   assign in_ready  = (r_fsm == READY) && !key_load;
   assign key_ready = r_keyReady;
   assign out_valid = r_outValid;
   assign busy      = r_busy;
   assign plaintext = r_data;

endmodule

// File: tb/tb_aes128_decrypt_iter.sv
// Bench for aes128_decrypt_iter: FIPS vectors, timing, backpressure, key priority,
// reset abort and random round trips against a table-based AES encryption model.
module tb_aes128_decrypt_iter;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         key_load = 1'b0;
   logic [127:0] key = '0;
   logic         key_ready;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [127:0] ciphertext = '0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [127:0] plaintext;
   logic         busy;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   logic [7:0] sboxTab [0:255];
   logic [7:0] alog [0:255];
   int         logTab [0:255];

   typedef struct {
      logic [127:0] key;
      logic [127:0] ct;
      logic [127:0] pt;
   } vec_t;

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] B_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

   aes128_decrypt_iter dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_load   (key_load),
      .key        (key),
      .key_ready  (key_ready),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .ciphertext (ciphertext),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .plaintext  (plaintext),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: time limit reached");
      $fatal(1, "[TB] time limit");
   end

   function automatic logic [7:0] xt(input logic [7:0] p);
      return {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      if (a == 8'h00 || b == 8'h00) return 8'h00;
      return alog[(logTab[a] + logTab[b]) % 255];
   endfunction

   // S-box from log/antilog tables (generator 3) plus the bitwise affine map.
   task automatic buildTables();
      logic [7:0] p, inv, s, c;
      p = 8'h01;
      c = 8'h63;
      for (int i = 0; i < 255; i++) begin
         alog[i] = p;
         logTab[p] = i;
         p = p ^ xt(p);
      end
      alog[255] = 8'h01;
      logTab[0] = 0;
      for (int x = 0; x < 256; x++) begin
         inv = (x == 0) ? 8'h00 : alog[(255 - logTab[x]) % 255];
         for (int i = 0; i < 8; i++)
            s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^
                   inv[(i + 7) % 8] ^ c[i];
         sboxTab[x] = s;
      end
   endtask

   function automatic logic [127:0] aesEncrypt(input logic [127:0] k, input logic [127:0] pt);
      logic [31:0]  w [0:43];
      logic [31:0]  t;
      logic [7:0]   rc;
      logic [7:0]   s [0:15];
      logic [7:0]   u [0:15];
      logic [127:0] rk;
      logic [127:0] res;
      rc = 8'h01;
      for (int i = 0; i < 44; i++) begin
         if (i < 4) begin
            w[i] = k[127 - 32*i -: 32];
         end else begin
            t = w[i-1];
            if (i % 4 == 0) begin
               t = {sboxTab[t[23:16]], sboxTab[t[15:8]], sboxTab[t[7:0]], sboxTab[t[31:24]]} ^
                   {rc, 24'h000000};
               rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
         end
      end
      for (int n = 0; n < 16; n++) s[n] = pt[127 - 8*n -: 8];
      for (int rnd = 0; rnd <= 10; rnd++) begin
         if (rnd > 0) begin
            for (int n = 0; n < 16; n++) u[n] = sboxTab[s[n]];
            for (int n = 0; n < 16; n++) s[n] = u[(n % 4) + 4*(((n / 4) + (n % 4)) % 4)];
            if (rnd < 10) begin
               for (int n = 0; n < 16; n++) u[n] = s[n];
               for (int c = 0; c < 4; c++) begin
                  s[4*c]   = gmul(u[4*c], 8'h02) ^ gmul(u[4*c+1], 8'h03) ^ u[4*c+2] ^ u[4*c+3];
                  s[4*c+1] = u[4*c] ^ gmul(u[4*c+1], 8'h02) ^ gmul(u[4*c+2], 8'h03) ^ u[4*c+3];
                  s[4*c+2] = u[4*c] ^ u[4*c+1] ^ gmul(u[4*c+2], 8'h02) ^ gmul(u[4*c+3], 8'h03);
                  s[4*c+3] = gmul(u[4*c], 8'h03) ^ u[4*c+1] ^ u[4*c+2] ^ gmul(u[4*c+3], 8'h02);
               end
            end
         end
         rk = {w[4*rnd], w[4*rnd+1], w[4*rnd+2], w[4*rnd+3]};
         for (int n = 0; n < 16; n++) s[n] = s[n] ^ rk[127 - 8*n -: 8];
      end
      for (int n = 0; n < 16; n++) res[127 - 8*n -: 8] = s[n];
      return res;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic loadKey(input logic [127:0] k, input string name);
      int n;
      key = k;
      key_load = 1'b1;
      tick();
      key_load = 1'b0;
      checkOutput({name, "_busy"}, busy, 1);
      n = 0;
      while (!key_ready && n < 40) begin
         tick();
         n++;
      end
      checkOutput({name, "_keyLat"}, n, 10);
   endtask

   task automatic applyStimulus(input logic [127:0] ct, input logic [127:0] expPt,
                                input string name, output int acc);
      int n;
      ciphertext = ct;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 40) begin
         tick();
         n++;
      end
      checkOutput({name, "_accept"}, in_ready, 1);
      acc = cyc;
      tick();
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 40) begin
         tick();
         n++;
      end
      checkOutput({name, "_lat"}, n, 10);
      checkOutput({name, "_pt"}, plaintext, expPt);
      if (out_ready) tick();
   endtask

   initial begin
      vec_t         vecs [4];
      int           acc [8];
      int           acc0;
      int           n;
      logic [127:0] k;
      logic [127:0] pts [8];
      logic [127:0] ptR;

      buildTables();

      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_keyReady", key_ready, 0);
      checkOutput("rst_inReady", in_ready, 0);
      checkOutput("rst_outValid", out_valid, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_plaintext", plaintext, 0);
      rst_n = 1'b1;
      tick();
      in_valid = 1'b1;
      tick();
      checkOutput("idle_inReady", in_ready, 0);
      checkOutput("idle_busy", busy, 0);
      in_valid = 1'b0;

      // Known-answer and random vectors, each with a fresh key.
      vecs[0].key = rand128();
      vecs[0].pt  = rand128();
      vecs[0].ct  = aesEncrypt(vecs[0].key, vecs[0].pt);
      vecs[1].key = rand128();
      vecs[1].pt  = rand128();
      vecs[1].ct  = aesEncrypt(vecs[1].key, vecs[1].pt);
      vecs[2]     = '{C1_KEY, C1_CT, C1_PT};
      vecs[3]     = '{B_KEY, B_CT, B_PT};
      for (int i = 0; i < 4; i++) begin
         loadKey(vecs[i].key, $sformatf("vec%0d", i));
         applyStimulus(vecs[i].ct, vecs[i].pt, $sformatf("vec%0d", i), acc0);
      end
      checkOutput("B_rk10", dut.r_rk[10], B_RK10);

      // key_load wins over in_valid in READY.
      key = C1_KEY;
      key_load = 1'b1;
      ciphertext = B_CT;
      in_valid = 1'b1;
      #1;
      checkOutput("prio_inReady", in_ready, 0);
      tick();
      key_load = 1'b0;
      in_valid = 1'b0;
      checkOutput("prio_keyReady", key_ready, 0);
      n = 0;
      while (!key_ready && n < 40) begin
         tick();
         n++;
      end
      checkOutput("prio_keyLat", n, 10);
      checkOutput("prio_noOut", out_valid, 0);
      applyStimulus(C1_CT, C1_PT, "prio_newKey", acc0);

      // key_load during ROUND is ignored.
      ptR = rand128();
      ciphertext = aesEncrypt(C1_KEY, ptR);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (3) tick();
      key = B_KEY;
      key_load = 1'b1;
      tick();
      key_load = 1'b0;
      checkOutput("midround_keyReady", key_ready, 1);
      n = 0;
      while (!out_valid && n < 40) begin
         tick();
         n++;
      end
      checkOutput("midround_pt", plaintext, ptR);
      tick();
      applyStimulus(C1_CT, C1_PT, "midround_bank", acc0);

      // Backpressure: result held while out_ready is low.
      out_ready = 1'b0;
      ptR = rand128();
      applyStimulus(aesEncrypt(C1_KEY, ptR), ptR, "bp", acc0);
      ciphertext = C1_CT;
      in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         checkOutput($sformatf("bp_hold%0d_pt", i), plaintext, ptR);
         checkOutput($sformatf("bp_hold%0d_inReady", i), in_ready, 0);
         checkOutput($sformatf("bp_hold%0d_outValid", i), out_valid, 1);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      checkOutput("bp_release_outValid", out_valid, 0);
      checkOutput("bp_release_inReady", in_ready, 1);
      checkOutput("bp_release_busy", busy, 0);

      // Back-to-back random round trips with out_ready held high.
      k = rand128();
      loadKey(k, "b2b");
      for (int i = 0; i < 8; i++) begin
         pts[i] = rand128();
         applyStimulus(aesEncrypt(k, pts[i]), pts[i], $sformatf("b2b%0d", i), acc[i]);
      end
      for (int i = 1; i < 8; i++)
         checkOutput($sformatf("b2b%0d_spacing", i), acc[i] - acc[i-1], 12);

      // Reset in the middle of ROUND aborts immediately.
      ciphertext = aesEncrypt(k, rand128());
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (5) tick();
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_keyReady", key_ready, 0);
      checkOutput("midrst_inReady", in_ready, 0);
      checkOutput("midrst_outValid", out_valid, 0);
      checkOutput("midrst_busy", busy, 0);
      checkOutput("midrst_plaintext", plaintext, 0);
      checkOutput("midrst_rk10", dut.r_rk[10], 0);
      tick();
      rst_n = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput($sformatf("postrst%0d_inReady", i), in_ready, 0);
         checkOutput($sformatf("postrst%0d_outValid", i), out_valid, 0);
      end
      in_valid = 1'b0;
      loadKey(C1_KEY, "postrst");
      applyStimulus(C1_CT, C1_PT, "postrst", acc0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
